// File: rtl/text_terminal_controller_if.sv
// Character stream, VGA fetch and character-RAM bundle for the terminal.
// Ports: code/valid/ready/fg/bg stream, fetch request, RAM bus, cursor, busy.
interface text_terminal_controller_if #(
   parameter int ADDR_W = 12
) ();
   logic [7:0]        code;
   logic              valid;
   logic              ready;
   logic [2:0]        fg;
   logic [2:0]        bg;
   logic              get_image_request;
   logic [6:0]        column;
   logic [4:0]        row;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [13:0]       ram_wr_data;
   logic [6:0]        cursor_column;
   logic [4:0]        cursor_row;
   logic              busy;

   modport master (
      output code, valid, fg, bg,
      output get_image_request, column, row,
      input  ready, ram_addr, ram_we, ram_wr_data,
      input  cursor_column, cursor_row, busy
   );

   modport slave (
      input  code, valid, fg, bg,
      input  get_image_request, column, row,
      output ready, ram_addr, ram_we, ram_wr_data,
      output cursor_column, cursor_row, busy
   );
endinterface

// File: rtl/text_terminal_controller.sv
// Text terminal sequencer and char-RAM arbiter for an 80x30 VGA screen.
// Ports: clk, rst (sync, active-high), bus (slave side of the bundle).
module text_terminal_controller #(
   parameter int COLUMNS = 80,
   parameter int ROWS    = 30,
   parameter int ADDR_W  = 12
) (
   input logic clk,
   input logic rst,
   text_terminal_controller_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE, WRITE_CHAR, CLEAR_LINE, CLEAR_ALL
   } state_t;

   localparam logic [6:0] LAST_COL = 7'(COLUMNS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
   localparam logic [ADDR_W-1:0] LAST_CELL =
      ADDR_W'(COLUMNS * ROWS - 1);
   localparam logic [ADDR_W-1:0] LINE_END =
      ADDR_W'(COLUMNS - 1);

   state_t            state, state_n;
   logic [6:0]        col, col_n;
   logic [4:0]        row, row_n;
   logic [4:0]        top_row, top_n;
   logic [ADDR_W-1:0] cnt, cnt_n;
   logic [7:0]        char_q;
   logic [2:0]        fg_q, bg_q;
   logic              busy_q;
   logic              take, nl, we, ready;
   logic              printable;
   logic [ADDR_W-1:0] waddr;

   // Screen row to RAM address, with the scroll offset folded in.
   function automatic logic [ADDR_W-1:0] map(
      input logic [4:0] r,
      input logic [6:0] c,
      input logic [4:0] top
   );
      logic [5:0]        s;
      logic [ADDR_W-1:0] p;
      s = {1'b0, r} + {1'b0, top};
      if (s >= 6'(ROWS))
         s = s - 6'(ROWS);
      p = ADDR_W'(s);
      return (p << 6) + (p << 4) + ADDR_W'(c);
   endfunction

   assign ready = (state == IDLE) && !rst;
   assign we = (state != IDLE) && !rst
      && !bus.get_image_request;
   assign printable = (bus.code >= 8'h20)
      && (bus.code <= 8'h7E);

   // The new bottom row after a scroll is screen row 29
   // under the updated offset, i.e. the old top row.
   always_comb begin
      waddr = cnt;
      unique case (state)
         WRITE_CHAR: waddr = map(row, col, top_row);
         CLEAR_LINE: waddr = map(LAST_ROW, cnt[6:0], top_row);
         default:    waddr = cnt;
      endcase
   end

   always_comb begin
      state_n = state;
      col_n   = col;
      row_n   = row;
      top_n   = top_row;
      cnt_n   = cnt;
      take    = 1'b0;
      nl      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.valid) begin
               take = 1'b1;
               unique case (1'b1)
                  printable: state_n = WRITE_CHAR;
                  bus.code == 8'h0D: col_n = '0;
                  bus.code == 8'h0A: begin
                     col_n = '0;
                     nl    = 1'b1;
                  end
                  bus.code == 8'h08: begin
                     if (col != 7'd0)
                        col_n = col - 7'd1;
                  end
                  bus.code == 8'h0C: begin
                     state_n = CLEAR_ALL;
                     col_n   = '0;
                     row_n   = '0;
                     top_n   = '0;
                     cnt_n   = '0;
                  end
                  default: ;
               endcase
            end
         end
         WRITE_CHAR: begin
            if (we) begin
               state_n = IDLE;
               if (col < LAST_COL) begin
                  col_n = col + 7'd1;
               end else begin
                  col_n = '0;
                  nl    = 1'b1;
               end
            end
         end
         CLEAR_LINE: begin
            if (we) begin
               if (cnt == LINE_END)
                  state_n = IDLE;
               else
                  cnt_n = cnt + 1'b1;
            end
         end
         CLEAR_ALL: begin
            if (we) begin
               if (cnt == LAST_CELL)
                  state_n = IDLE;
               else
                  cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = CLEAR_ALL;
      endcase
      if (nl) begin
         if (row < LAST_ROW) begin
            row_n = row + 5'd1;
         end else begin
            top_n = (top_row == LAST_ROW) ?
               5'd0 : top_row + 5'd1;
            state_n = CLEAR_LINE;
            cnt_n   = '0;
         end
      end
   end

   // Colours track the inputs during reset so the power-up
   // clear uses whatever the source presents at release.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR_ALL;
         cnt     <= '0;
         col     <= '0;
         row     <= '0;
         top_row <= '0;
         busy_q  <= 1'b1;
         char_q  <= 8'h20;
         fg_q    <= bus.fg;
         bg_q    <= bus.bg;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         col     <= col_n;
         row     <= row_n;
         top_row <= top_n;
         busy_q  <= (state_n != IDLE);
         if (take) begin
            char_q <= bus.code;
            fg_q   <= bus.fg;
            bg_q   <= bus.bg;
         end
      end
   end

   assign bus.ready = ready;
   assign bus.ram_we = we;
   assign bus.ram_addr = bus.get_image_request ?
      map(bus.row, bus.column, top_row) : waddr;
   assign bus.ram_wr_data = {fg_q, bg_q,
      (state == WRITE_CHAR) ? char_q : 8'h20};
   assign bus.cursor_column = col;
   assign bus.cursor_row = row;
   assign bus.busy = busy_q;
endmodule

// File: tb/tb_text_terminal_controller.sv
// Directed bench for text_terminal_controller with a write scoreboard.
// Ports: none; drives the interface bundle and checks RAM writes.
module tb_text_terminal_controller;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   text_terminal_controller_if #(.ADDR_W(12)) bus ();

   text_terminal_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad = 0;
   logic [25:0] sb[$];

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h",
            tag, obs, expv);
      end
   endtask

   function automatic void push(input logic [11:0] a,
                                input logic [13:0] d);
      sb.push_back({a, d});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] c);
      int n;
      n = 0;
      bus.code = c;
      bus.valid = 1'b1;
      while (!bus.ready && n < 5000) begin
         tick();
         n++;
      end
      check("accept_ready", 32'(bus.ready), 32'd1);
      tick();
      bus.valid = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (!bus.ready && n < 5000) begin
         tick();
         n++;
      end
   endtask

   task automatic fetch(input logic [4:0] r,
                        input logic [6:0] c,
                        input logic [11:0] a,
                        input string tag);
      bus.get_image_request = 1'b1;
      bus.row = r;
      bus.column = c;
      #1;
      check(tag, 32'(bus.ram_addr), 32'(a));
      bus.get_image_request = 1'b0;
      #1;
   endtask

   always @(negedge clk) begin
      logic [25:0] e;
      logic has;
      if (!rst) begin
         if (bus.get_image_request)
            check("we_during_fetch", 32'(bus.ram_we), 32'd0);
         if (bus.ram_we) begin
            has = (sb.size() != 0);
            check("write_expected", 32'(has), 32'd1);
            if (has) begin
               e = sb.pop_front();
               check("wr_addr", 32'(bus.ram_addr), 32'(e[25:14]));
               check("wr_data", 32'(bus.ram_wr_data), 32'(e[13:0]));
            end
         end
      end
   end

   initial begin
      int n;
      logic [7:0] c;
      rst = 1'b1;
      bus.code = 8'h00;
      bus.valid = 1'b0;
      bus.fg = 3'b111;
      bus.bg = 3'b000;
      bus.get_image_request = 1'b0;
      bus.column = 7'd0;
      bus.row = 5'd0;
      repeat (3) tick();
      check("rst_ready", 32'(bus.ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd1);
      check("rst_we", 32'(bus.ram_we), 32'd0);
      check("rst_col", 32'(bus.cursor_column), 32'd0);
      check("rst_row", 32'(bus.cursor_row), 32'd0);

      for (int i = 0; i < 2400; i++)
         push(12'(i), 14'h3820);
      rst = 1'b0;
      n = 0;
      while (!bus.ready && n < 3000) begin
         tick();
         n++;
      end
      check("boot_clear_cycles", 32'(n), 32'd2400);
      check("boot_sb_empty", 32'(sb.size()), 32'd0);
      check("boot_col", 32'(bus.cursor_column), 32'd0);
      check("boot_row", 32'(bus.cursor_row), 32'd0);
      check("boot_busy", 32'(bus.busy), 32'd0);

      bus.bg = 3'b001;
      push(12'd0, 14'h3941);
      send(8'h41);
      check("char_ready_low", 32'(bus.ready), 32'd0);
      check("char_busy", 32'(bus.busy), 32'd1);
      tick();
      check("char_ready_back", 32'(bus.ready), 32'd1);
      check("char_col", 32'(bus.cursor_column), 32'd1);
      check("char_row", 32'(bus.cursor_row), 32'd0);

      push(12'd1, 14'h3942);
      send(8'h42);
      bus.get_image_request = 1'b1;
      bus.row = 5'd2;
      bus.column = 7'd5;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_addr", 32'(bus.ram_addr), 32'd165);
         check("stall_we", 32'(bus.ram_we), 32'd0);
         check("stall_ready", 32'(bus.ready), 32'd0);
         tick();
      end
      bus.get_image_request = 1'b0;
      #1;
      check("release_we", 32'(bus.ram_we), 32'd1);
      check("release_addr", 32'(bus.ram_addr), 32'd1);
      tick();
      check("release_ready", 32'(bus.ready), 32'd1);
      check("release_col", 32'(bus.cursor_column), 32'd2);

      send(8'h0D);
      check("cr_col", 32'(bus.cursor_column), 32'd0);
      check("cr_row", 32'(bus.cursor_row), 32'd0);
      for (int i = 0; i < 80; i++) begin
         c = 8'h30 + 8'(i % 10);
         push(12'(i), {3'b111, 3'b001, c});
         send(c);
      end
      wait_idle(n);
      check("line_col", 32'(bus.cursor_column), 32'd0);
      check("line_row", 32'(bus.cursor_row), 32'd1);
      check("line_sb_empty", 32'(sb.size()), 32'd0);
      fetch(5'd0, 7'd0, 12'd0, "noscroll_r0");
      fetch(5'd1, 7'd3, 12'd83, "noscroll_r1");

      repeat (28) send(8'h0A);
      check("lf_row", 32'(bus.cursor_row), 32'd29);
      check("lf_col", 32'(bus.cursor_column), 32'd0);
      send(8'h08);
      check("bs0_col", 32'(bus.cursor_column), 32'd0);
      check("bs0_row", 32'(bus.cursor_row), 32'd29);

      bus.fg = 3'b010;
      bus.bg = 3'b100;
      for (int i = 0; i < 80; i++)
         push(12'(i), 14'h1420);
      send(8'h0A);
      wait_idle(n);
      check("scroll_cycles", 32'(n), 32'd80);
      check("scroll_col", 32'(bus.cursor_column), 32'd0);
      check("scroll_row", 32'(bus.cursor_row), 32'd29);
      check("scroll_sb_empty", 32'(sb.size()), 32'd0);
      fetch(5'd0, 7'd0, 12'd80, "scroll_r0");
      fetch(5'd29, 7'd0, 12'd0, "scroll_r29");
      fetch(5'd29, 7'd79, 12'd79, "scroll_r29c79");

      push(12'd0, 14'h1458);
      send(8'h58);
      wait_idle(n);
      check("bottom_col", 32'(bus.cursor_column), 32'd1);
      send(8'h08);
      check("bs1_col", 32'(bus.cursor_column), 32'd0);
      check("bs1_row", 32'(bus.cursor_row), 32'd29);

      bus.fg = 3'b110;
      bus.bg = 3'b011;
      for (int i = 0; i < 2400; i++)
         push(12'(i), 14'h3320);
      push(12'd0, 14'h3343);
      send(8'h0C);
      bus.code = 8'h43;
      bus.valid = 1'b1;
      n = 0;
      while (!bus.ready && n < 3000) begin
         bus.get_image_request = (n >= 100 && n < 105);
         bus.row = 5'd0;
         bus.column = 7'd0;
         tick();
         n++;
         if (n == 50) begin
            check("ff_busy", 32'(bus.busy), 32'd1);
            check("ff_mid_col", 32'(bus.cursor_column), 32'd0);
            check("ff_mid_row", 32'(bus.cursor_row), 32'd0);
         end
      end
      bus.get_image_request = 1'b0;
      check("ff_cycles", 32'(n), 32'd2405);
      check("ff_held_pending", 32'(sb.size()), 32'd1);
      check("ff_col", 32'(bus.cursor_column), 32'd0);
      check("ff_row", 32'(bus.cursor_row), 32'd0);
      tick();
      bus.valid = 1'b0;
      tick();
      check("after_ff_col", 32'(bus.cursor_column), 32'd1);
      check("after_ff_row", 32'(bus.cursor_row), 32'd0);
      fetch(5'd0, 7'd0, 12'd0, "ff_top_r0");
      fetch(5'd29, 7'd0, 12'd2320, "ff_top_r29");
      repeat (3) tick();
      check("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/text_terminal_controller.md
Name: text_terminal_controller

Overview:
- Sequencer and arbiter for the single-port character RAM that feeds the 640x480 80x30 text VGA generator.
- Accepts an ASCII byte stream from a UART or CPU with a valid/ready handshake.
- Interprets control codes, maintains the cursor, performs hardware scrolling via a top-row offset, and performs line and screen clears.
- Shares the RAM port between its own writes and the VGA character fetches; VGA fetches always have priority.

Parameters:
- COLUMNS, 80, characters per row.
- ROWS, 30, character rows per screen.
- ADDR_W, 12, RAM address width (COLUMNS*ROWS = 2400 < 4096).

Ports:
- Clock  in  1  pixel clock, 25 MHz.
- Reset  in  1  synchronous, active-high.
- Char_i  in  8  input character code.
- CharValid_i  in  1  Char_i valid.
- CharReady_o  out  1  controller can accept a character this cycle.
- ColorForeground_i  in  3  RGB foreground stored with each printable character and with each clear.
- ColorBackground_i  in  3  RGB background, same usage.
- GetImageRequest_i  in  1  VGA fetch strobe.
- Column_i  in  7  VGA column, 0..79.
- Row_i  in  5  VGA screen row, 0..29.
- RamAddr_o  out  ADDR_W  RAM address.
- RamWe_o  out  1  RAM write enable.
- RamWrData_o  out  14  write data {fg[2:0], bg[2:0], char[7:0]}.
- CursorColumn_o  out  7  cursor column.
- CursorRow_o  out  5  cursor screen row.
- Busy_o  out  1  a clear or write is in progress.

Behaviour:
- Clock and reset:
  - One clock domain only.
  - Reset is synchronous and active-high.
  - While Reset=1: state=CLEAR_ALL, clear counter=0, cursor=(0,0), TopRow=0, CharReady_o=0, Busy_o=1, RamWe_o=0.
  - After release, CLEAR_ALL runs automatically.
- Address mapping:
  - phys_row = (row + TopRow) mod 30.
  - addr = phys_row*80 + col, computed as (r<<6)+(r<<4)+col.
  - Maximum address is 2399.
- Arbitration (combinational):
  - When GetImageRequest_i=1: RamAddr_o = map(Row_i, Column_i), RamWe_o=0, and any pending write stalls.
  - When GetImageRequest_i=0 and a write is pending: RamAddr_o = write address, RamWe_o=1. The write completes on that edge.
  - Otherwise RamWe_o=0.
- States:
  - IDLE:
    - CharReady_o=1 and Busy_o=0.
    - On CharValid_i & CharReady_o, latch Char_i and the colours, then decode.
  - WRITE_CHAR:
    - One pending write of {fg, bg, char} at the cursor.
    - On completion, advance the cursor and go to IDLE.
  - CLEAR_LINE:
    - Writes 80 cells {fg, bg, 0x20} at phys_row*80 + k, k = 0..79.
    - k increments only on completed writes. Go to IDLE after k=79 completes.
  - CLEAR_ALL:
    - Writes addresses 0..2399 with {fg, bg, 0x20}.
    - At entry, sets TopRow=0 and cursor=(0,0). Go to IDLE after 2399 completes.
- Decode, on the accept cycle:
  - 0x20..0x7E: go to WRITE_CHAR.
  - 0x0D (CR): col=0, stay in IDLE.
  - 0x0A (LF): col=0, then newline.
  - 0x08 (BS): if col>0 then col-1, otherwise no change. No erase.
  - 0x0C (FF): go to CLEAR_ALL.
  - Any other code: ignored, stay in IDLE.
- Cursor advance after a printable write:
  - If col<79: col+1.
  - If col=79: col=0, then newline.
- Newline:
  - If row<29: row+1.
  - If row=29: row stays 29, TopRow = (TopRow==29) ? 0 : TopRow+1, then CLEAR_LINE of the new bottom row (physical row = old TopRow).
- Latency:
  - A character accepted in cycle N is written in cycle N+1 if GetImageRequest_i=0, otherwise at the first later cycle with GetImageRequest_i=0.
  - CharReady_o returns to 1 in the cycle after the write.
- Clear durations with no VGA requests: CLEAR_LINE takes 80 cycles, CLEAR_ALL takes 2400 cycles.
  - Each cycle with GetImageRequest_i=1 adds one cycle.
- CharReady_o is 0 in every state except IDLE. The input is never dropped: the source holds Char_i and CharValid_i until accepted.
- Reset mid-operation: abort any write or clear immediately, then restart CLEAR_ALL from address 0.
- CursorColumn_o, CursorRow_o and Busy_o are registered.

Test Plan:
- Release Reset with GetImageRequest_i=0, fg=3'b111, bg=3'b000:
  - Required: 2400 writes, addresses 0..2399, data 14'h3820.
  - Required: CharReady_o=1 exactly 2400 cycles after release.
  - Required: cursor=(0,0).
- Send 0x41 with fg=3'b111, bg=3'b001 at (0,0):
  - Required: one write, address 0, data 14'h3941.
  - Required: cursor=(1,0). CharReady_o low for 1 cycle only.
- Hold GetImageRequest_i=1 with Row_i=2, Column_i=5, TopRow=0, while a write is pending:
  - Required: RamAddr_o=165 and RamWe_o=0 while the request is high.
  - Required: the write lands on the first cycle with the request low.
- Send 80 printable characters from (0,0):
  - Required: writes to addresses 0..79.
  - Required: cursor=(0,1) and no scroll.
- With cursor row 29 and TopRow=0, send 0x0A:
  - Required: TopRow=1, followed by 80 space writes to addresses 0..79. Cursor=(0,29).
  - Required: a VGA fetch at Row_i=0, Column_i=0 gives RamAddr_o=80.
  - Required: a VGA fetch at Row_i=29, Column_i=0 gives RamAddr_o=0.
- Send 0x08 at col 0: required, cursor unchanged.
- Send 0x0C mid-text:
  - Required: full 2400-write clear, TopRow=0, cursor=(0,0).
  - Required: CharValid_i held during the clear is not accepted until the clear finishes.
